// File: rtl/seq_comparator_if.sv
// rtl/seq_comparator_if.sv - operand/result bundle between the operand latch and the comparator
interface seq_comparator_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, eq, gt, lt
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, eq, gt, lt
    );
endinterface

// File: rtl/seq_comparator.sv
// rtl/seq_comparator.sv - MSB-first 2-bit-per-cycle magnitude comparator with early exit
module seq_comparator #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    seq_comparator_if.slave cmp
);
    localparam int SLICES = WIDTH / 2;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx_q;
    logic             chain_eq_q;
    logic             chain_gt_q;
    logic             busy_q;
    logic             done_q;
    logic             eq_q;
    logic             gt_q;
    logic             lt_q;

    logic             chain_eq_d;
    logic             chain_gt_d;
    logic [1:0]       a_sl;
    logic [1:0]       b_sl;
    logic [WIDTH-1:0] sign_flip;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign sign_flip = {cmp.signed_mode, {(WIDTH-1){1'b0}}};

    always_comb begin
        a_sl       = a_q[{idx_q, 1'b0} +: 2];
        b_sl       = b_q[{idx_q, 1'b0} +: 2];
        chain_eq_d = chain_eq_q;
        chain_gt_d = chain_gt_q;
        if (chain_eq_q) begin
            chain_eq_d = (a_sl == b_sl);
            chain_gt_d = (a_sl > b_sl);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            idx_q      <= LAST_IDX;
            chain_eq_q <= 1'b0;
            chain_gt_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            eq_q       <= 1'b0;
            gt_q       <= 1'b0;
            lt_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (cmp.start) begin
                        a_q        <= cmp.a ^ sign_flip;
                        b_q        <= cmp.b ^ sign_flip;
                        idx_q      <= LAST_IDX;
                        chain_eq_q <= 1'b1;
                        chain_gt_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RUN;
                    end else begin
                        state_q    <= S_IDLE;
                    end
                end
                S_RUN: begin
                    chain_eq_q <= chain_eq_d;
                    chain_gt_q <= chain_gt_d;
                    idx_q      <= idx_q - 1'b1;
                    // Stop as soon as a slice differs; otherwise run to the LSB slice.
                    if (!chain_eq_d || idx_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        eq_q    <= chain_eq_d;
                        gt_q    <= chain_gt_d;
                        lt_q    <= ~chain_eq_d & ~chain_gt_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmp.busy = busy_q;
    assign cmp.done = done_q;
    assign cmp.eq   = eq_q;
    assign cmp.gt   = gt_q;
    assign cmp.lt   = lt_q;
endmodule

// File: tb/tb_seq_comparator.sv
// tb/tb_seq_comparator.sv - scoreboard bench for seq_comparator
module tb_seq_comparator;
    localparam int WIDTH = 32;

    typedef struct {
        logic eq;
        logic gt;
        logic lt;
        int   k;
        int   e0;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   busy_cnt = 0;
    exp_t sb[$];

    seq_comparator_if #(.WIDTH(WIDTH)) cmp_if ();

    seq_comparator #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .cmp   (cmp_if)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input int e0);
        exp_t r;
        if (s) begin
            r.gt = $signed(a) > $signed(b);
            r.lt = $signed(a) < $signed(b);
        end else begin
            r.gt = a > b;
            r.lt = a < b;
        end
        r.eq = (a == b);
        r.k  = 0;
        for (int i = WIDTH/2 - 1; i >= 0; i--) begin
            r.k++;
            if (a[2*i +: 2] != b[2*i +: 2]) break;
        end
        r.e0 = e0;
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit track);
        cmp_if.start       = 1'b1;
        cmp_if.a           = a;
        cmp_if.b           = b;
        cmp_if.signed_mode = s;
        if (track) sb.push_back(model(a, b, s, cyc + 1));
        step();
        cmp_if.start       = 1'b0;
        cmp_if.a           = $urandom;
        cmp_if.b           = $urandom;
        cmp_if.signed_mode = 1'($urandom_range(1));
    endtask

    task automatic wait_idle(input int budget);
        int left = budget;
        while (sb.size() != 0 && left > 0) begin
            step();
            left--;
        end
        chk("timeout_pending", 32'(sb.size()), 32'd0);
        step();
    endtask

    always @(negedge clock) begin
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (cmp_if.busy) busy_cnt++;
            if (cmp_if.done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(cmp_if.done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", 32'(cyc), 32'(e.e0 + e.k));
                    chk("busy_cycles", 32'(busy_cnt), 32'(e.k));
                    chk("eq", 32'(cmp_if.eq), 32'(e.eq));
                    chk("gt", 32'(cmp_if.gt), 32'(e.gt));
                    chk("lt", 32'(cmp_if.lt), 32'(e.lt));
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cmp_if.start       = 1'b0;
        cmp_if.a           = '0;
        cmp_if.b           = '0;
        cmp_if.signed_mode = 1'b0;
        repeat (3) step();
        chk("rst_busy", 32'(cmp_if.busy), 32'd0);
        chk("rst_done", 32'(cmp_if.done), 32'd0);
        chk("rst_eq",   32'(cmp_if.eq),   32'd0);
        chk("rst_gt",   32'(cmp_if.gt),   32'd0);
        chk("rst_lt",   32'(cmp_if.lt),   32'd0);
        reset = 1'b0;
        step();

        issue(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
        wait_idle(40);
        issue(32'h8000_0000, 32'h4000_0000, 1'b0, 1'b1);
        wait_idle(40);
        issue(32'h8000_0000, 32'h4000_0000, 1'b1, 1'b1);
        wait_idle(40);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);
        wait_idle(40);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        wait_idle(40);

        issue(32'h0000_0002, 32'h0000_0003, 1'b0, 1'b1);
        repeat (3) step();
        cmp_if.start = 1'b1;
        cmp_if.a     = 32'hFFFF_0000;
        cmp_if.b     = 32'h0000_FFFF;
        step();
        cmp_if.start = 1'b0;
        wait_idle(40);
        repeat (20) step();
        chk("hold_lt", 32'(cmp_if.lt), 32'd1);
        chk("hold_eq", 32'(cmp_if.eq), 32'd0);

        issue(32'h8000_0000, 32'h4000_0000, 1'b0, 1'b1);
        step();
        issue(32'h0000_00F0, 32'h0000_00E0, 1'b0, 1'b1);
        wait_idle(60);

        repeat (6) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(3) == 0) ? ra : (ra ^ (32'h1 << $urandom_range(31)));
            issue(ra, rb, 1'($urandom_range(1)), 1'b1);
            wait_idle(40);
        end

        issue(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
        wait_idle(40);
        issue(32'hABCD_0000, 32'hABCD_0000, 1'b0, 1'b0);
        repeat (4) step();
        reset = 1'b1;
        step();
        chk("mid_rst_busy", 32'(cmp_if.busy), 32'd0);
        chk("mid_rst_done", 32'(cmp_if.done), 32'd0);
        chk("mid_rst_eq",   32'(cmp_if.eq),   32'd0);
        chk("mid_rst_gt",   32'(cmp_if.gt),   32'd0);
        chk("mid_rst_lt",   32'(cmp_if.lt),   32'd0);
        reset = 1'b0;
        repeat (24) step();
        chk("post_rst_idle", 32'(cmp_if.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
